// File: rtl/arbitro_mux_rr.sv
// arbitro_mux_rr: round-robin arbiter over four FWFT input FIFOs feeding a
// two-way destination demux. One word per cycle is popped from an eligible
// FIFO (non-empty and whose destination FIFO is not almost-full) and forwarded
// on a registered output, with per-destination and stall statistics.
module arbitro_mux_rr #(
  parameter int DATA_W = 6,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] fifo_data_0,
  input  logic [DATA_W-1:0] fifo_data_1,
  input  logic [DATA_W-1:0] fifo_data_2,
  input  logic [DATA_W-1:0] fifo_data_3,
  input  logic [3:0]        fifo_empty,
  input  logic [1:0]        d_almost_full,
  output logic [3:0]        pop,
  output logic [DATA_W-1:0] mux_arbitro_1,
  output logic              valid_out,
  output logic [CNT_W-1:0]  cnt_d0,
  output logic [CNT_W-1:0]  cnt_d1,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Bit of the word that selects the destination FIFO (0 -> D0, 1 -> D1).
  localparam int DEST_BIT = 4;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_STALL  = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [1:0]        rr_ptr_r;
  logic [DATA_W-1:0] head_s [4];
  logic [3:0]        elig_s;
  logic              any_elig_s;
  logic              any_ne_s;
  logic [1:0]        cand_s;
  logic [1:0]        grant_idx_s;
  logic              grant_vld_s;
  logic [3:0]        pop_s;
  logic              pop_fire_s;
  logic [DATA_W-1:0] grant_data_s;

  assign head_s[0] = fifo_data_0;
  assign head_s[1] = fifo_data_1;
  assign head_s[2] = fifo_data_2;
  assign head_s[3] = fifo_data_3;

  // A FIFO is eligible when it has a head word and that word's destination has room.
  always_comb begin
    elig_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      elig_s[i] = ~fifo_empty[i] & ~d_almost_full[head_s[i][DEST_BIT]];
    end
  end

  assign any_elig_s = |elig_s;
  assign any_ne_s   = ~&fifo_empty;

  // Round-robin search from rr_ptr; scanning offsets high-to-low lets the
  // closest eligible index (smallest offset) be the last, winning assignment.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = 2'd0;
    cand_s      = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      cand_s      = rr_ptr_r + k[1:0];
      grant_idx_s = elig_s[cand_s] ? cand_s : grant_idx_s;
      grant_vld_s = elig_s[cand_s] | grant_vld_s;
    end
  end

  assign grant_data_s = head_s[grant_idx_s];

  // Next-state and one-hot pop; pops only in ACTIVE, never while in reset.
  always_comb begin
    state_next_s = ST_IDLE;
    pop_s        = 4'b0000;
    if (!reset_L) begin
      state_next_s = ST_IDLE;
      pop_s        = 4'b0000;
    end else begin
      case (state_r)
        ST_ACTIVE: pop_s = grant_vld_s ? (4'b0001 << grant_idx_s) : 4'b0000;
        ST_IDLE:   pop_s = 4'b0000;
        ST_STALL:  pop_s = 4'b0000;
        default:   pop_s = 4'b0000;
      endcase
      if (any_elig_s) begin
        state_next_s = ST_ACTIVE;
      end else if (any_ne_s) begin
        state_next_s = ST_STALL;
      end else begin
        state_next_s = ST_IDLE;
      end
    end
  end

  assign pop        = pop_s;
  assign pop_fire_s = |pop_s;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Forwarded word register, valid flag and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      mux_arbitro_1 <= {DATA_W{1'b0}};
      valid_out     <= 1'b0;
      rr_ptr_r      <= 2'd0;
    end else begin
      valid_out <= pop_fire_s;
      if (pop_fire_s) begin
        mux_arbitro_1 <= grant_data_s;
        rr_ptr_r      <= grant_idx_s + 2'd1;
      end
    end
  end

  // Per-destination forwarded-word counters, wrapping.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      cnt_d0 <= {CNT_W{1'b0}};
      cnt_d1 <= {CNT_W{1'b0}};
    end else if (pop_fire_s) begin
      if (grant_data_s[DEST_BIT]) begin
        cnt_d1 <= cnt_d1 + CNT_ONE;
      end else begin
        cnt_d0 <= cnt_d0 + CNT_ONE;
      end
    end
  end

  // Stall-cycle counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      stall_cnt <= {CNT_W{1'b0}};
    end else if ((state_r == ST_STALL) && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule
